tone_sequencer: RTL and testbench
=================================

Name: tone_sequencer

Overview:
- Sequences the tone generator through a programmable melody of up to SEQ_LEN steps.
- Drives the generator's `select`, `enable` and `reset` inputs and times note and gap durations.
- Forwards the generator's 24-bit sample stream to the audio codec FIFO using the codec's `allowed`/`write` handshake.
- Sits between the top-level control (keys/switches) and the tone generator / codec output.

Parameters:
- SEQ_LEN, 8, number of melody steps; power of two; index width IW = log2(SEQ_LEN).
- NOTE_TICKS, 12500000, clk cycles a note sounds (must be >= 2).
- GAP_TICKS, 1250000, clk cycles of silence after each note (must be >= 1).
- CW, 24, width of the duration counters.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  level; sampled in IDLE, begins playback at step 0.
- stop  in  1  level; aborts playback, returns to IDLE.
- loop  in  1  level; when high, wraps from the last step to step 0 instead of finishing.
- prog_we  in  1  write strobe into the step table.
- prog_addr  in  IW  step table address.
- prog_note  in  3  note code for the step (generator `select`).
- prog_rest  in  1  1 = step is a rest (generator disabled for the note time).
- audio_in  in  24  sample from the tone generator.
- audio_out_allowed  in  1  codec FIFO has space.
- tone_select  out  3  to generator `select`.
- tone_enable  out  1  to generator `enable`.
- tone_reset  out  1  to generator `reset`.
- left_channel_audio_out  out  24  sample to codec.
- right_channel_audio_out  out  24  sample to codec.
- write_audio_out  out  1  codec write strobe.
- busy  out  1  high in any state except IDLE.
- step_index  out  IW  current step.
- done  out  1  one-cycle pulse on normal completion.

Behaviour:
- Reset: clk and reset as named above; reset is synchronous, active-high.
  - All outputs go to 0; state = IDLE; counters = 0.
  - The step table is NOT cleared by reset.
- Step table: SEQ_LEN x 4 bits, written on posedge clk when prog_we=1, regardless of state.
  - A write to the step currently playing takes effect at that step's next LOAD.
- States: IDLE, LOAD, PLAY, GAP, FINISH.
- IDLE:
  - Outputs: tone_enable=0, tone_reset=0.
  - start=1 and stop=0 -> LOAD, with step_index=0.
  - stop has priority over start.
- LOAD (exactly 1 cycle):
  - tone_select <= table note; tone_reset=1; tone_enable=0; duration counter <= NOTE_TICKS-1.
  - Next state is PLAY.
- PLAY:
  - tone_reset=0; tone_enable = ~rest bit.
  - Counter decrements each cycle; at 0 -> GAP with counter <= GAP_TICKS-1.
  - The note occupies exactly NOTE_TICKS cycles of PLAY.
- GAP:
  - tone_enable=0; counter decrements; at 0:
    - If step_index != SEQ_LEN-1: step_index+1 -> LOAD.
    - If it is the last step and loop=1: step_index=0 -> LOAD.
    - Otherwise -> FINISH.
  - step_index wraps modulo SEQ_LEN.
- FINISH (1 cycle): done=1 -> IDLE.
  - step_index keeps its last value until the next start.
- stop=1 in LOAD, PLAY, GAP or FINISH:
  - Next cycle: IDLE, tone_enable=0, tone_reset=1 for that one cycle, no done pulse.
  - stop beats counter expiry in the same cycle.
- Period: one full step = 1 + NOTE_TICKS + GAP_TICKS cycles.
- start held high through FINISH retriggers only after returning to IDLE, i.e. the restart LOAD comes 1 cycle after IDLE.
- Codec path (registered):
  - Each cycle: left = right = (tone_enable ? audio_in : 0).
  - write_audio_out = audio_out_allowed & busy, registered with 1 cycle latency.
  - When audio_out_allowed is low, the sample registers hold and write_audio_out=0.
  - Samples are never written in IDLE.
- Counter width: CW must hold max(NOTE_TICKS, GAP_TICKS)-1; no other arithmetic saturates.

Test Plan:
All scenarios use SEQ_LEN=4, NOTE_TICKS=8, GAP_TICKS=2.
1. Program notes {1,3,5,7}, rest=0, loop=0; pulse start.
   - Expect LOAD with tone_select=1 and tone_reset=1, then 8 cycles of enable=1, then 2 cycles of enable=0, repeated per step.
   - done pulses exactly 1 cycle, 44 cycles after LOAD of step 0; busy falls on the next cycle.
2. Mark step 2 as a rest.
   - Expect tone_enable=0 and codec samples = 0 for all 8 PLAY cycles of step 2; tone_select still = table note.
3. loop=1.
   - After step 3's GAP, step_index=0 and LOAD occurs; no done pulse.
   - Deassert loop mid-step 1 -> finishes after step 3.
4. Assert stop on the 4th PLAY cycle of step 1.
   - Next cycle: IDLE, enable=0, tone_reset=1 for 1 cycle, done=0.
   - Assert stop and start together in IDLE -> remains IDLE.
5. Hold audio_out_allowed=0 for 5 cycles during PLAY with audio_in=24'h00BB80.
   - write_audio_out=0 throughout and samples hold.
   - On release, write resumes 1 cycle later with left=right=24'h00BB80.
6. Assert reset during GAP.
   - Next cycle: all outputs are 0 and state is IDLE; the table retains its contents, confirmed by replaying with start.

Source files
------------

// File: rtl/tone_sequencer_if.sv
// Tone generator and audio codec signal bundle driven by the tone sequencer.
// The master side sequences the generator and feeds the codec FIFO.
interface tone_sequencer_if;
  logic [2:0]  tone_select;
  logic        tone_enable;
  logic        tone_reset;
  logic [23:0] audio_in;
  logic        audio_out_allowed;
  logic [23:0] left_channel_audio_out;
  logic [23:0] right_channel_audio_out;
  logic        write_audio_out;

  modport master (
    output tone_select,
    output tone_enable,
    output tone_reset,
    output left_channel_audio_out,
    output right_channel_audio_out,
    output write_audio_out,
    input  audio_in,
    input  audio_out_allowed
  );

  modport slave (
    input  tone_select,
    input  tone_enable,
    input  tone_reset,
    input  left_channel_audio_out,
    input  right_channel_audio_out,
    input  write_audio_out,
    output audio_in,
    output audio_out_allowed
  );
endinterface

// File: rtl/tone_sequencer.sv
// Plays a programmable melody on the tone generator, timing note and gap
// durations, and forwards the generator's samples to the codec FIFO.
module tone_sequencer #(
  parameter int  SEQ_LEN    = 8,
  parameter int  NOTE_TICKS = 12500000,
  parameter int  GAP_TICKS  = 1250000,
  parameter int  CW         = 24,
  localparam int IW         = $clog2(SEQ_LEN)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             loop,
  input  logic             prog_we,
  input  logic [IW-1:0]    prog_addr,
  input  logic [2:0]       prog_note,
  input  logic             prog_rest,
  tone_sequencer_if.master gen,
  output logic             busy,
  output logic [IW-1:0]    step_index,
  output logic             done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_PLAY,
    S_GAP,
    S_FINISH
  } state_t;

  typedef struct packed {
    logic       rest;
    logic [2:0] note;
  } step_t;

  localparam logic [CW-1:0] NOTE_LAST = CW'(NOTE_TICKS - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_TICKS - 1);
  localparam logic [IW-1:0] LAST_STEP = IW'(SEQ_LEN - 1);

  step_t         step_table [SEQ_LEN];

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  step_t         cur_q, cur_d;
  logic          en_q, en_d;
  logic          rst_q, rst_d;
  logic          done_q;
  logic [23:0]   sample_q;
  logic          write_q;

  // NOTE: the melody table is deliberately left out of reset so a programmed
  // tune survives a reset and can be replayed with start.
  always_ff @(posedge clk) begin
    if (prog_we) begin
      step_table[prog_addr] <= {prog_rest, prog_note};
    end
  end

  // Outputs are registered from the next-state decision so that tone_select,
  // tone_reset and tone_enable line up with the state they describe.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    cur_d   = cur_q;
    en_d    = 1'b0;
    rst_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          state_d = S_LOAD;
          idx_d   = '0;
        end
      end
      S_LOAD: begin
        state_d = S_PLAY;
        cnt_d   = NOTE_LAST;
        en_d    = ~cur_q.rest;
      end
      S_PLAY: begin
        if (cnt_q == '0) begin
          state_d = S_GAP;
          cnt_d   = GAP_LAST;
        end else begin
          cnt_d = cnt_q - 1'b1;
          en_d  = ~cur_q.rest;
        end
      end
      S_GAP: begin
        if (cnt_q == '0) begin
          if (idx_q != LAST_STEP) begin
            state_d = S_LOAD;
            idx_d   = idx_q + 1'b1;
          end else if (loop) begin
            state_d = S_LOAD;
            idx_d   = '0;
          end else begin
            state_d = S_FINISH;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // The step is fetched on entry to LOAD, so a table write to the playing
    // step only shows up the next time that step is loaded.
    if (state_d == S_LOAD) begin
      cur_d = step_table[idx_d];
      rst_d = 1'b1;
    end

    // Abort wins over everything else, including counter expiry.
    if (stop && state_q != S_IDLE) begin
      state_d = S_IDLE;
      idx_d   = idx_q;
      cnt_d   = '0;
      cur_d   = cur_q;
      en_d    = 1'b0;
      rst_d   = 1'b1;
    end
  end

  // NOTE: state is updated with non-blocking assignments only; the comb block
  // above uses blocking ones because it describes logic, not storage.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      cur_q   <= '0;
      en_q    <= 1'b0;
      rst_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      cur_q   <= cur_d;
      en_q    <= en_d;
      rst_q   <= rst_d;
      done_q  <= (state_d == S_FINISH);
    end
  end

  // Codec path: samples hold while the FIFO is full; silence when disabled.
  always_ff @(posedge clk) begin
    if (reset) begin
      sample_q <= '0;
      write_q  <= 1'b0;
    end else begin
      write_q <= gen.audio_out_allowed & busy;
      if (gen.audio_out_allowed) begin
        sample_q <= en_q ? gen.audio_in : 24'd0;
      end
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign step_index = idx_q;
  assign done       = done_q;

  assign gen.tone_select             = cur_q.note;
  assign gen.tone_enable             = en_q;
  assign gen.tone_reset              = rst_q;
  assign gen.left_channel_audio_out  = sample_q;
  assign gen.right_channel_audio_out = sample_q;
  assign gen.write_audio_out         = write_q;

endmodule

// File: tb/tb_tone_sequencer.sv
// Bench for tone_sequencer: a step-timeline model checked every cycle plus
// directed scenarios with hand-computed timing points.
module tb_tone_sequencer;
  localparam int L = 4;
  localparam int N = 8;
  localparam int G = 2;
  localparam int P = 1 + N + G;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       loop = 1'b0;
  logic       prog_we = 1'b0;
  logic [1:0] prog_addr = '0;
  logic [2:0] prog_note = '0;
  logic       prog_rest = 1'b0;
  logic       busy;
  logic [1:0] step_index;
  logic       done;

  tone_sequencer_if gen();

  tone_sequencer #(
    .SEQ_LEN(L), .NOTE_TICKS(N), .GAP_TICKS(G), .CW(24)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .loop(loop),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_note(prog_note),
    .prog_rest(prog_rest), .gen(gen), .busy(busy),
    .step_index(step_index), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int en_cnt = 0;
  bit cmp_on = 1'b0;
  bit hold_audio = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each step is a timeline of P cycles (0 = load, 1..N = note,
  // N+1..N+G = gap); finishing adds one done cycle.
  logic [3:0]  m_table [L];
  bit          m_active, m_fin, m_stop_rst, m_rest, m_write;
  int          m_pos, m_step;
  logic [2:0]  m_note;
  logic [23:0] m_sample;

  function automatic bit exp_busy();
    return m_active || m_fin;
  endfunction

  function automatic bit exp_en();
    return m_active && m_pos >= 1 && m_pos <= N && !m_rest;
  endfunction

  function automatic bit exp_rst();
    return (m_active && m_pos == 0) || m_stop_rst;
  endfunction

  initial begin : model
    bit busy_now, en_now;
    foreach (m_table[i]) m_table[i] = '0;
    forever begin
      @(posedge clk);
      busy_now = exp_busy();
      en_now   = exp_en();
      if (reset) begin
        m_active = 0; m_fin = 0; m_stop_rst = 0; m_rest = 0; m_write = 0;
        m_pos = 0; m_step = 0; m_note = '0; m_sample = '0;
      end else begin
        m_write = gen.audio_out_allowed && busy_now;
        if (gen.audio_out_allowed) m_sample = en_now ? gen.audio_in : 24'd0;
        m_stop_rst = 0;
        if (stop && busy_now) begin
          m_active = 0; m_fin = 0; m_stop_rst = 1;
        end else if (m_fin) begin
          m_fin = 0;
        end else if (m_active) begin
          if (m_pos == P - 1) begin
            if (m_step != L - 1 || loop) begin
              m_step = (m_step + 1) % L;
              m_pos  = 0;
              m_note = m_table[m_step][2:0];
              m_rest = m_table[m_step][3];
            end else begin
              m_active = 0; m_fin = 1;
            end
          end else begin
            m_pos++;
          end
        end else if (start && !stop) begin
          m_active = 1; m_pos = 0; m_step = 0;
          m_note = m_table[0][2:0];
          m_rest = m_table[0][3];
        end
      end
      if (prog_we) m_table[prog_addr] = {prog_rest, prog_note};
    end
  end

  initial begin : compare
    forever begin
      @(negedge clk);
      if (cmp_on) begin
        check("busy",        32'(busy),                        32'(exp_busy()));
        check("done",        32'(done),                        32'(m_fin));
        check("step_index",  32'(step_index),                  32'(m_step));
        check("tone_select", 32'(gen.tone_select),             32'(m_note));
        check("tone_enable", 32'(gen.tone_enable),             32'(exp_en()));
        check("tone_reset",  32'(gen.tone_reset),              32'(exp_rst()));
        check("write",       32'(gen.write_audio_out),         32'(m_write));
        check("left",        32'(gen.left_channel_audio_out),  32'(m_sample));
        check("right",       32'(gen.right_channel_audio_out), 32'(m_sample));
      end
    end
  end

  initial begin : audio_driver
    gen.audio_in = '0;
    forever begin
      @(negedge clk);
      gen.audio_in = hold_audio ? 24'h00BB80 : 24'($urandom);
    end
  end

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (gen.tone_enable) en_cnt++;
  endtask

  task automatic program_step(input int a, input int n, input bit r);
    @(negedge clk);
    prog_we = 1; prog_addr = 2'(a); prog_note = 3'(n); prog_rest = r;
    @(negedge clk);
    prog_we = 0;
  endtask

  // Leaves the bench at the negedge of the LOAD cycle of step 0 (cyc = 0).
  task automatic start_pulse();
    @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    cyc = 0;
    en_cnt = 0;
  endtask

  task automatic wait_done(input string name, input int exp_at);
    int at = -1;
    for (int i = 0; i < 120; i++) begin
      tick();
      if (done) begin
        at = cyc;
        break;
      end
    end
    check(name, 32'(at), 32'(exp_at));
    tick();
    check({name, "_pulse_end"}, 32'(done), 32'd0);
    check({name, "_busy_low"},  32'(busy), 32'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not terminate, errors so far %0d", errors);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    gen.audio_out_allowed = 1'b1;
    @(posedge clk);
    #1 cmp_on = 1;
    @(negedge clk);
    @(negedge clk);
    check("rst_busy",   32'(busy),                       32'd0);
    check("rst_select", 32'(gen.tone_select),            32'd0);
    check("rst_write",  32'(gen.write_audio_out),        32'd0);
    check("rst_left",   32'(gen.left_channel_audio_out), 32'd0);
    reset = 0;

    // 1: plain four-note melody
    program_step(0, 1, 0);
    program_step(1, 3, 0);
    program_step(2, 5, 0);
    program_step(3, 7, 0);
    start_pulse();
    check("t1_load_reset",  32'(gen.tone_reset),  32'd1);
    check("t1_load_select", 32'(gen.tone_select), 32'd1);
    check("t1_load_enable", 32'(gen.tone_enable), 32'd0);
    tick();
    check("t1_play_enable", 32'(gen.tone_enable), 32'd1);
    while (cyc < 11) tick();
    check("t1_step1_select", 32'(gen.tone_select), 32'd3);
    check("t1_step1_reset",  32'(gen.tone_reset),  32'd1);
    wait_done("t1_done_at", 44);
    check("t1_enable_cycles", 32'(en_cnt), 32'd32);

    // 2: step 2 becomes a rest
    program_step(2, 5, 1);
    start_pulse();
    while (cyc < 25) tick();
    check("t2_rest_enable", 32'(gen.tone_enable), 32'd0);
    check("t2_rest_select", 32'(gen.tone_select), 32'd5);
    check("t2_rest_step",   32'(step_index),      32'd2);
    while (cyc < 27) tick();
    check("t2_rest_left",  32'(gen.left_channel_audio_out),  32'd0);
    check("t2_rest_right", 32'(gen.right_channel_audio_out), 32'd0);
    wait_done("t2_done_at", 44);
    check("t2_enable_cycles", 32'(en_cnt), 32'd24);

    // 3: loop back to step 0, then drop loop mid step 1
    loop = 1;
    start_pulse();
    while (cyc < 44) tick();
    check("t3_wrap_reset", 32'(gen.tone_reset), 32'd1);
    check("t3_wrap_step",  32'(step_index),     32'd0);
    check("t3_wrap_done",  32'(done),           32'd0);
    while (cyc < 60) tick();
    loop = 0;
    wait_done("t3_done_at", 88);

    // 4: stop on the 4th note cycle of step 1, then stop+start in idle
    start_pulse();
    while (cyc < 15) tick();
    stop = 1;
    tick();
    check("t4_stop_busy",   32'(busy),            32'd0);
    check("t4_stop_enable", 32'(gen.tone_enable), 32'd0);
    check("t4_stop_reset",  32'(gen.tone_reset),  32'd1);
    check("t4_stop_done",   32'(done),            32'd0);
    check("t4_stop_step",   32'(step_index),      32'd1);
    start = 1;
    tick();
    check("t4_reset_once", 32'(gen.tone_reset), 32'd0);
    tick();
    check("t4_idle_held", 32'(busy), 32'd0);
    start = 0;
    stop = 0;
    tick();

    // 5: codec back-pressure for 5 cycles during a note
    start_pulse();
    tick();
    hold_audio = 1;
    gen.audio_out_allowed = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t5_write_blocked", 32'(gen.write_audio_out), 32'd0);
    end
    gen.audio_out_allowed = 1;
    tick();
    check("t5_write_resume", 32'(gen.write_audio_out),         32'd1);
    check("t5_left_sample",  32'(gen.left_channel_audio_out),  32'h00BB80);
    check("t5_right_sample", 32'(gen.right_channel_audio_out), 32'h00BB80);
    hold_audio = 0;
    wait_done("t5_done_at", 44);

    // 6: reset during a gap; the table must survive
    start_pulse();
    while (cyc < 9) tick();
    check("t6_in_gap", 32'(gen.tone_enable), 32'd0);
    reset = 1;
    tick();
    check("t6_busy",   32'(busy),                        32'd0);
    check("t6_reset",  32'(gen.tone_reset),              32'd0);
    check("t6_select", 32'(gen.tone_select),             32'd0);
    check("t6_step",   32'(step_index),                  32'd0);
    check("t6_write",  32'(gen.write_audio_out),         32'd0);
    check("t6_left",   32'(gen.left_channel_audio_out),  32'd0);
    reset = 0;
    start_pulse();
    check("t6_replay_select", 32'(gen.tone_select), 32'd1);
    while (cyc < 33) tick();
    check("t6_replay_step3", 32'(gen.tone_select), 32'd7);
    wait_done("t6_done_at", 44);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
